// File: rtl/mod60_pkg.sv
//------------------------------------------------------------------------------
// Module      : mod60_pkg
// Description : Shared digit limits and widths for the BCD modulo-60 counter.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mod60_pkg;
    localparam int UNITS_MAX = 9;
    localparam int TENS_MAX  = 5;
    localparam int UNITS_W   = 4;
    localparam int TENS_W    = 3;
    localparam int COUNT_MAX = TENS_MAX * 10 + UNITS_MAX;
endpackage : mod60_pkg

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
//------------------------------------------------------------------------------
// Module      : bcd_digit_counter
// Description : One BCD digit, 0..MAX, with load, up/down step and en-gated tc.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_counter #(
    parameter int MAX   = 9,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (up) begin
                cnt_d = (cnt_q == c_max) ? '0 : cnt_q + c_one;
            end else begin
                cnt_d = (cnt_q == '0) ? c_max : cnt_q - c_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= rst_val;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count is the wrap point in the current direction, only while stepping.
    assign tc = en & (up ? (cnt_q == c_max) : (cnt_q == '0));
    assign q  = cnt_q;

endmodule : bcd_digit_counter

`default_nettype wire

// File: rtl/bcd_mod60_counter.sv
//------------------------------------------------------------------------------
// Module      : bcd_mod60_counter
// Description : Two-digit BCD 00..59 counter with load, tc and carry pulse.
//               Define MOD60_DOWN_EN to add the up_dn direction input.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_mod60_counter
    import mod60_pkg::*;
#(
    parameter int RESET_VALUE = 0
) (
`ifdef MOD60_DOWN_EN
    input  logic              up_dn,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [TENS_W-1:0]  load_tens,
    input  logic [UNITS_W-1:0] load_units,
    output logic [TENS_W-1:0]  tens,
    output logic [UNITS_W-1:0] units,
    output logic              tc,
    output logic              carry
);

    localparam int c_rv = ((RESET_VALUE >= 0) && (RESET_VALUE <= COUNT_MAX)) ? RESET_VALUE : 0;
    localparam logic [TENS_W-1:0]  c_rst_tens  = TENS_W'(c_rv / 10);
    localparam logic [UNITS_W-1:0] c_rst_units = UNITS_W'(c_rv % 10);
    localparam logic [TENS_W-1:0]  c_tens_max  = TENS_W'(TENS_MAX);
    localparam logic [UNITS_W-1:0] c_units_max = UNITS_W'(UNITS_MAX);

    logic                w_up;
    logic [TENS_W-1:0]   w_load_tens;
    logic [UNITS_W-1:0]  w_load_units;
    logic                w_units_tc;
    logic                w_tens_tc;
    logic                carry_q;
    logic                carry_d;

`ifdef MOD60_DOWN_EN
    assign w_up = up_dn;
`else
    assign w_up = 1'b1;
`endif

    // Illegal load digits clamp to the digit maximum so the state stays valid BCD.
    assign w_load_tens  = (load_tens  > c_tens_max)  ? c_tens_max  : load_tens;
    assign w_load_units = (load_units > c_units_max) ? c_units_max : load_units;

    bcd_digit_counter #(
        .MAX   (UNITS_MAX),
        .WIDTH (UNITS_W)
    ) u_units (
        .clk      (clk),
        .rst      (rst),
        .rst_val  (c_rst_units),
        .en       (en),
        .up       (w_up),
        .load     (load),
        .load_val (w_load_units),
        .q        (units),
        .tc       (w_units_tc)
    );

    bcd_digit_counter #(
        .MAX   (TENS_MAX),
        .WIDTH (TENS_W)
    ) u_tens (
        .clk      (clk),
        .rst      (rst),
        .rst_val  (c_rst_tens),
        .en       (w_units_tc),
        .up       (w_up),
        .load     (load),
        .load_val (w_load_tens),
        .q        (tens),
        .tc       (w_tens_tc)
    );

    // Tens tc already includes en and the units wrap, so it marks the full 00/59 wrap.
    assign tc      = w_tens_tc;
    assign carry_d = load ? 1'b0 : tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;

endmodule : bcd_mod60_counter

`default_nettype wire

// File: tb/tb_bcd_mod60_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_mod60_counter
// Description : Directed vector table plus wrap sequences for bcd_mod60_counter.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_mod60_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_tens = 3'd0;
    logic [3:0] load_units = 4'd0;
    logic       up_dn = 1'b1;
    logic [2:0] tens;
    logic [3:0] units;
    logic       tc;
    logic       carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_mod60_counter #(
        .RESET_VALUE (0)
    ) dut (
`ifdef MOD60_DOWN_EN
        .up_dn      (up_dn),
`endif
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_tens  (load_tens),
        .load_units (load_units),
        .tens       (tens),
        .units      (units),
        .tc         (tc),
        .carry      (carry)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [2:0] lt;
        logic [3:0] lu;
        logic       exp_tc;
        int         exp_t;
        int         exp_u;
        logic       exp_c;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive inputs at negedge, check tc before the edge, then state/carry after it.
    task automatic step(input string tag, input logic r, input logic e, input logic l,
                        input logic [2:0] lt, input logic [3:0] lu, input logic exp_tc,
                        input int exp_t, input int exp_u, input logic exp_c);
        @(negedge clk);
        rst = r; en = e; load = l; load_tens = lt; load_units = lu;
        #1;
        chk({tag, ".tc"}, {31'd0, tc}, {31'd0, exp_tc});
        @(posedge clk);
        #1;
        chk({tag, ".tens"},  {29'd0, tens},  exp_t);
        chk({tag, ".units"}, {28'd0, units}, exp_u);
        chk({tag, ".carry"}, {31'd0, carry}, {31'd0, exp_c});
    endtask

    initial begin
        int cur;
        int ncarry;
        int last_carry;

        //           rst en ld lt  lu  tc  T  U  c
        vecs[0]  = '{1, 0, 0, 3'd0, 4'd0,  0, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 3'd7, 4'd12, 0, 5, 9, 0};
        vecs[2]  = '{0, 1, 0, 3'd0, 4'd0,  1, 0, 0, 1};
        vecs[3]  = '{0, 0, 0, 3'd0, 4'd0,  0, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 3'd5, 4'd9,  0, 5, 9, 0};
        vecs[5]  = '{0, 1, 1, 3'd3, 4'd4,  1, 3, 4, 0};
        vecs[6]  = '{0, 0, 1, 3'd5, 4'd9,  0, 5, 9, 0};
        vecs[7]  = '{1, 1, 0, 3'd0, 4'd0,  1, 0, 0, 0};
        vecs[8]  = '{0, 0, 1, 3'd0, 4'd8,  0, 0, 8, 0};
        vecs[9]  = '{0, 1, 0, 3'd0, 4'd0,  0, 0, 9, 0};
        vecs[10] = '{0, 0, 0, 3'd0, 4'd0,  0, 0, 9, 0};
        vecs[11] = '{0, 1, 0, 3'd0, 4'd0,  0, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 3'd0, 4'd0,  0, 1, 0, 0};
        vecs[13] = '{0, 1, 1, 3'd2, 4'd9,  0, 2, 9, 0};
        vecs[14] = '{0, 1, 0, 3'd0, 4'd0,  0, 3, 0, 0};
        vecs[15] = '{0, 0, 1, 3'd6, 4'd15, 0, 5, 9, 0};
        vecs[16] = '{0, 0, 1, 3'd4, 4'd10, 0, 4, 9, 0};

        up_dn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].load,
                 vecs[i].lt, vecs[i].lu, vecs[i].exp_tc, vecs[i].exp_t,
                 vecs[i].exp_u, vecs[i].exp_c);
        end

        // Full up-count from reset through two wraps; carry every 60 steps.
        step("up_rst", 1, 0, 0, 3'd0, 4'd0, 0, 0, 0, 0);
        cur = 0;
        ncarry = 0;
        last_carry = -1;
        for (int i = 0; i < 120; i++) begin
            logic etc;
            etc = (cur == 59);
            cur = (cur + 1) % 60;
            step($sformatf("up%0d", i), 0, 1, 0, 3'd0, 4'd0, etc, cur / 10, cur % 10, cur == 0);
            if (carry === 1'b1) begin
                if (last_carry >= 0) chk("carry_spacing", i - last_carry, 60);
                last_carry = i;
                ncarry++;
            end
        end
        chk("carry_count", ncarry, 2);

`ifdef MOD60_DOWN_EN
        up_dn = 1'b0;
        step("dn_ld00", 0, 0, 1, 3'd0, 4'd0, 0, 0, 0, 0);
        step("dn_wrap", 0, 1, 0, 3'd0, 4'd0, 1, 5, 9, 1);
        step("dn_hold", 0, 0, 0, 3'd0, 4'd0, 0, 5, 9, 0);
        step("dn_ld10", 0, 0, 1, 3'd1, 4'd0, 0, 1, 0, 0);
        step("dn_borrow", 0, 1, 0, 3'd0, 4'd0, 0, 0, 9, 0);
        step("dn_ld00b", 0, 0, 1, 3'd0, 4'd0, 0, 0, 0, 0);
        cur = 0;
        for (int i = 0; i < 60; i++) begin
            logic etc;
            etc = (cur == 0);
            cur = (cur + 59) % 60;
            step($sformatf("dn%0d", i), 0, 1, 0, 3'd0, 4'd0, etc, cur / 10, cur % 10, cur == 59);
        end
        up_dn = 1'b1;
`endif

        @(negedge clk);
        en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bcd_mod60_counter

`default_nettype wire
